// File: rtl/packet_scheduler.sv
// packet_scheduler: per-slot data-island packet arbiter (ACR, N InfoFrames, urgent/normal audio,
// null). Define PACKET_SCHEDULER_STATS_EN to add per-frame audio/null packet counters.
module packet_scheduler #(
   parameter int unsigned                  NUM_INFOFRAMES  = 2,
   parameter logic [NUM_INFOFRAMES*8-1:0]  INFOFRAME_TYPES = {8'h82, 8'h84},
   parameter logic [7:0]                   URGENT_LEVEL    = 8'd4,
   parameter logic [7:0]                   ACR_TYPE        = 8'd1,
   parameter logic [7:0]                   AUDIO_TYPE      = 8'd2
) (
   input  logic                      clk_pixel,
   input  logic                      reset,
   input  logic                      frame_start,
   input  logic                      packet_enable,
   input  logic [7:0]                audio_remaining,
   input  logic [NUM_INFOFRAMES-1:0] infoframe_enable,
   output logic [7:0]                packet_type,
   output logic                      audio_pop,
`ifdef PACKET_SCHEDULER_STATS_EN
   output logic [NUM_INFOFRAMES:0]   missed,
   output logic [15:0]               audio_count,
   output logic [15:0]               null_count
`else
   output logic [NUM_INFOFRAMES:0]   missed
`endif
);

   if (URGENT_LEVEL == 8'd0) begin : g_bad_urgent
      $error("packet_scheduler: URGENT_LEVEL must be nonzero");
   end
   if (NUM_INFOFRAMES < 1 || NUM_INFOFRAMES > 8) begin : g_bad_num
      $error("packet_scheduler: NUM_INFOFRAMES must be in 1..8");
   end

   logic                      acr_pending_q, acr_pending_d;
   logic [NUM_INFOFRAMES-1:0] if_pending_q, if_pending_d;
   logic [7:0]                packet_type_q, packet_type_d;
   logic                      audio_pop_q, audio_pop_d;
   logic [NUM_INFOFRAMES:0]   missed_q, missed_d;

   // Flags as seen by this cycle's selection: a frame_start re-arms before choosing.
   logic                      acr_armed;
   logic [NUM_INFOFRAMES-1:0] if_armed;
   logic                      if_any;
   logic [NUM_INFOFRAMES-1:0] if_onehot;
   logic [7:0]                if_type;
   logic                      sel_audio;
   logic                      sel_null;

   always_comb begin
      acr_armed = frame_start ? 1'b1 : acr_pending_q;
      if_armed  = frame_start ? infoframe_enable : if_pending_q;
   end

   // Lowest set index wins; the descending loop lets the last hit overwrite.
   always_comb begin
      if_any    = 1'b0;
      if_onehot = '0;
      if_type   = 8'd0;
      for (int i = int'(NUM_INFOFRAMES) - 1; i >= 0; i--) begin
         if (if_armed[i]) begin
            if_any       = 1'b1;
            if_onehot    = '0;
            if_onehot[i] = 1'b1;
            if_type      = INFOFRAME_TYPES[i*8 +: 8];
         end
      end
   end

   always_comb begin
      acr_pending_d = acr_armed;
      if_pending_d  = if_armed;
      packet_type_d = packet_type_q;
      audio_pop_d   = 1'b0;
      missed_d      = frame_start ? {if_pending_q, acr_pending_q} : missed_q;
      sel_audio     = 1'b0;
      sel_null      = 1'b0;

      if (packet_enable) begin
         if (acr_armed) begin
            packet_type_d = ACR_TYPE;
            acr_pending_d = 1'b0;
         end else if (audio_remaining >= URGENT_LEVEL) begin
            packet_type_d = AUDIO_TYPE;
            audio_pop_d   = 1'b1;
            sel_audio     = 1'b1;
         end else if (if_any) begin
            packet_type_d = if_type;
            if_pending_d  = if_armed & ~if_onehot;
         end else if (audio_remaining != 8'd0) begin
            packet_type_d = AUDIO_TYPE;
            audio_pop_d   = 1'b1;
            sel_audio     = 1'b1;
         end else begin
            packet_type_d = 8'd0;
            sel_null      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         acr_pending_q <= 1'b1;
         if_pending_q  <= infoframe_enable;
         packet_type_q <= 8'd0;
         audio_pop_q   <= 1'b0;
         missed_q      <= '0;
      end else begin
         acr_pending_q <= acr_pending_d;
         if_pending_q  <= if_pending_d;
         packet_type_q <= packet_type_d;
         audio_pop_q   <= audio_pop_d;
         missed_q      <= missed_d;
      end
   end

   assign packet_type = packet_type_q;
   assign audio_pop   = audio_pop_q;
   assign missed      = missed_q;

`ifdef PACKET_SCHEDULER_STATS_EN
   logic [15:0] audio_cnt_q, audio_cnt_d;
   logic [15:0] null_cnt_q, null_cnt_d;
   logic [15:0] audio_count_q, audio_count_d;
   logic [15:0] null_count_q, null_count_d;
   logic [15:0] audio_base, null_base;

   // A selection in the frame_start cycle counts toward the new frame.
   always_comb begin
      audio_base    = frame_start ? 16'd0 : audio_cnt_q;
      null_base     = frame_start ? 16'd0 : null_cnt_q;
      audio_cnt_d   = audio_base;
      null_cnt_d    = null_base;
      audio_count_d = frame_start ? audio_cnt_q : audio_count_q;
      null_count_d  = frame_start ? null_cnt_q : null_count_q;
      if (sel_audio && audio_base != 16'hFFFF) begin
         audio_cnt_d = audio_base + 16'd1;
      end
      if (sel_null && null_base != 16'hFFFF) begin
         null_cnt_d = null_base + 16'd1;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         audio_cnt_q   <= 16'd0;
         null_cnt_q    <= 16'd0;
         audio_count_q <= 16'd0;
         null_count_q  <= 16'd0;
      end else begin
         audio_cnt_q   <= audio_cnt_d;
         null_cnt_q    <= null_cnt_d;
         audio_count_q <= audio_count_d;
         null_count_q  <= null_count_d;
      end
   end

   assign audio_count = audio_count_q;
   assign null_count  = null_count_q;
`else
   logic unused_sel;
   assign unused_sel = sel_audio ^ sel_null;
`endif

endmodule
